rsa_byte_seq: RTL
=================

RSA_BYTE_SEQ -- requirements
Module: rsa_byte_seq

Interface
REQ-001 Parameter NBYTES, 32: bytes per operand; the core uses 5-bit addr, so addr = byte index 0..NBYTES-1.
REQ-002 Parameter TIMEOUT_CYC, 1048576: cycle budget for core completion (used only with RSA_SEQ_TIMEOUT_EN).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  host byte available.
REQ-006 in_data  in  8  host byte.
REQ-007 in_ready  out  1  sequencer accepts in_data this cycle.
REQ-008 out_valid  out  1  result byte available.
REQ-009 out_data  out  8  result byte.
REQ-010 out_ready  in  1  host consumes out_data.
REQ-011 core_we_n  out  1  active-low write strobe to RSA core.
REQ-012 core_oe_n  out  1  active-low read strobe to RSA core.
REQ-013 core_reg_sel  out  2  core register select: 3 = modulus, 1 = base, 2 = exponent, 0 = result.
REQ-014 core_addr  out  5  core byte address.
REQ-015 core_wdata  out  8  byte to core.
REQ-016 core_rdata  in  8  core read data, registered, valid the cycle after the oe_n strobe.
REQ-017 core_start_n  out  1  active-low one-cycle start pulse.
REQ-018 core_ready  in  1  core done (high = idle/complete).
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 err  out  1  sticky timeout flag; cleared by reset or the next accepted byte in IDLE.

Function
REQ-021 States: IDLE, LOAD_N, LOAD_M, LOAD_E, START, WAIT_BUSY, WAIT_DONE, RD_REQ, RD_CAP, SEND.
REQ-022 IDLE: in_ready = 1; the first accepted byte is written as modulus addr 0, and the FSM enters LOAD_N with byte count 1.
REQ-023 Each byte is accepted when in_valid and in_ready are both high; in the same cycle core_we_n = 0, core_wdata = in_data, core_addr = count, and core_reg_sel is per state.
REQ-024 Operand order is modulus, then base, then exponent, each least-significant byte first; at count = NBYTES-1 the counter wraps to 0 and the FSM advances.
REQ-025 After the last exponent byte: START drives core_start_n = 0 for exactly 1 cycle, and in_ready = 0 from then until IDLE.
REQ-026 WAIT_BUSY waits for core_ready = 0, then WAIT_DONE waits for core_ready = 1; a stale high ready therefore never completes the operation.
REQ-027 RD_REQ drives core_reg_sel = 0, core_addr = count, core_oe_n = 0 for 1 cycle; RD_CAP registers core_rdata into out_data.
REQ-028 SEND holds out_valid = 1 with out_data stable until out_ready; then count increments and the FSM goes to RD_REQ, or to IDLE after byte NBYTES-1.
REQ-029 Worst-case read throughput is 1 byte per 3 cycles; out_valid never asserts outside SEND.
REQ-030 core_we_n and core_oe_n are never low in the same cycle; both idle high.
REQ-031 in_valid while in_ready = 0 is ignored; the byte is not lost from the host's view (standard valid/ready).

Reset
REQ-032 On reset assertion the FSM goes to IDLE immediately, regardless of current state, including mid-load or mid-wait.
REQ-033 Reset values: count = 0, in_ready = 1, out_valid = 0, out_data = 0, core_we_n = 1, core_oe_n = 1, core_start_n = 1, core_reg_sel = 0, core_addr = 0, core_wdata = 0, busy = 0, err = 0.

Configuration
REQ-034 RSA_SEQ_TIMEOUT_EN defined: a counter runs in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYC the FSM sets err = 1 and returns to IDLE without reading.
REQ-035 RSA_SEQ_TIMEOUT_EN undefined: there is no counter, waits are unbounded, and err is tied to 0.

Structure
REQ-036 Package rsa_pkg holds the reg_sel constants (RSEL_RES, RSEL_BASE, RSEL_EXP, RSEL_MOD), the state enum, and NBYTES_DEF = 32.
REQ-037 Sub-module rsa_seq_timeout (counter with clear/enable/expire) is instantiated only under RSA_SEQ_TIMEOUT_EN; everything else is a single FSM.

Verification
REQ-038 Stream 96 bytes (N = 0xC5, base = 0x02, exponent = 0x03 in byte 0, all other bytes zero) -> core sees 96 we_n pulses in order reg_sel 3,1,2 with addr 0..31 each, then one start_n pulse.
REQ-039 Core model with result 8 (0x08 at addr 0) -> out stream is 0x08 followed by 31 bytes of 0x00, then busy = 0.
REQ-040 out_ready held low 10 cycles on byte 5 -> out_data stays stable and no core_oe_n pulse occurs until it is accepted.
REQ-041 core_ready held high through start, drops after 4 cycles, rises after 50 -> the first RD_REQ comes only after the rise.
REQ-042 Reset asserted after 40 input bytes -> all outputs at reset values asynchronously; the next stream restarts at modulus addr 0.
REQ-043 With RSA_SEQ_TIMEOUT_EN and TIMEOUT_CYC = 100, core_ready stuck low -> err = 1 at cycle 100 of the wait, the FSM is in IDLE, and no out_valid occurs.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: register selects, FSM encoding and load helpers
// shared by the RSA byte sequencer and its bus interface.
package rsa_pkg;

    localparam int unsigned NBYTES_DEF = 32;
    localparam int unsigned AW         = 5;

    localparam logic [1:0] RSEL_RES  = 2'd0;
    localparam logic [1:0] RSEL_BASE = 2'd1;
    localparam logic [1:0] RSEL_EXP  = 2'd2;
    localparam logic [1:0] RSEL_MOD  = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_N,
        LOAD_M,
        LOAD_E,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RD_REQ,
        RD_CAP,
        SEND
    } state_t;

    function automatic logic [1:0] load_sel(input state_t s);
        logic [1:0] r;
        unique case (1'b1)
            (s == LOAD_M): r = RSEL_BASE;
            (s == LOAD_E): r = RSEL_EXP;
            default:       r = RSEL_MOD;
        endcase
        return r;
    endfunction

    function automatic state_t load_next(input state_t s);
        state_t r;
        unique case (1'b1)
            (s == LOAD_M): r = LOAD_E;
            (s == LOAD_E): r = START;
            default:       r = LOAD_M;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rsa_byte_seq_if.sv
// rsa_byte_seq_if: host byte streams plus the RSA core register bus.
// master is the sequencer side, slave is the host/core side.
interface rsa_byte_seq_if;
    import rsa_pkg::*;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          core_we_n;
    logic          core_oe_n;
    logic [1:0]    core_reg_sel;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_wdata;
    logic [7:0]    core_rdata;
    logic          core_start_n;
    logic          core_ready;

    modport master (
        input  in_valid, in_data, out_ready,
        input  core_rdata, core_ready,
        output in_ready, out_valid, out_data,
        output core_we_n, core_oe_n, core_reg_sel,
        output core_addr, core_wdata, core_start_n
    );

    modport slave (
        output in_valid, in_data, out_ready,
        output core_rdata, core_ready,
        input  in_ready, out_valid, out_data,
        input  core_we_n, core_oe_n, core_reg_sel,
        input  core_addr, core_wdata, core_start_n
    );

endinterface

// File: rtl/rsa_seq_timeout.sv
// rsa_seq_timeout: cycle counter with clear/enable that flags
// the LIMIT-th enabled cycle since the last clear.
module rsa_seq_timeout #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned TW = $clog2(LIMIT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == TW'(LIMIT - 1));

endmodule

// File: rtl/rsa_byte_seq.sv
// rsa_byte_seq: loads modulus/base/exponent bytes into an RSA core, starts it,
// then streams the result back. RSA_SEQ_TIMEOUT_EN bounds the core wait.
module rsa_byte_seq
    import rsa_pkg::*;
#(
    parameter int unsigned NBYTES      = NBYTES_DEF,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic           clk,
    input  logic           reset,
    rsa_byte_seq_if.master bus,
    output logic           busy,
    output logic           err
);
    localparam logic [AW-1:0] LAST = AW'(NBYTES - 1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] count;
    logic [AW-1:0] count_n;
    logic [7:0]    rd_q;
    logic [1:0]    sel;
    logic          in_rdy;
    logic          acc;
    logic          oe_n;
    logic          start_n;
    logic          tmo;

    assign in_rdy = state inside {IDLE, LOAD_N, LOAD_M, LOAD_E};
    // no write strobe may leak to the core while reset is held
    assign acc    = in_rdy && bus.in_valid && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (state == RD_CAP) begin
                rd_q <= bus.core_rdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        sel     = RSEL_RES;
        oe_n    = 1'b1;
        start_n = 1'b1;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    sel     = RSEL_MOD;
                    count_n = AW'(1);
                    state_n = LOAD_N;
                end
            end
            LOAD_N, LOAD_M, LOAD_E: begin
                sel = load_sel(state);
                if (acc) begin
                    count_n = count + 1'b1;
                    if (count == LAST) begin
                        count_n = '0;
                        state_n = load_next(state);
                    end
                end
            end
            START: begin
                start_n = 1'b0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.core_ready) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.core_ready) begin
                    state_n = RD_REQ;
                end
            end
            RD_REQ: begin
                oe_n    = 1'b0;
                state_n = RD_CAP;
            end
            RD_CAP: begin
                state_n = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    count_n = count + 1'b1;
                    state_n = RD_REQ;
                    if (count == LAST) begin
                        count_n = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
        if (tmo) begin
            count_n = '0;
            state_n = IDLE;
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = (state == SEND);
    assign bus.out_data     = rd_q;
    assign bus.core_we_n    = !acc;
    assign bus.core_oe_n    = oe_n;
    assign bus.core_start_n = start_n;
    assign bus.core_reg_sel = sel;
    assign bus.core_addr    = count;
    assign bus.core_wdata   = acc ? bus.in_data : 8'h00;
    assign busy             = (state != IDLE);

`ifdef RSA_SEQ_TIMEOUT_EN
    logic waiting;
    logic err_q;

    assign waiting = state inside {WAIT_BUSY, WAIT_DONE};

    rsa_seq_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (!waiting),
        .en     (waiting),
        .expire (tmo)
    );

    // sticky until the host starts a fresh operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (tmo) begin
            err_q <= 1'b1;
        end else if (state == IDLE && acc) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_tmo_cfg;

    assign tmo            = 1'b0;
    assign err            = 1'b0;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

endmodule
